// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data memory responder.
//   dmem_state_e : responder FSM states (IDLE / WAIT / RESP)
//   BE_W         : byte enables per word
//   DATA_W       : data word width
//   LAT_CNT_W    : latency counter width (holds LATENCY-1, max 14)
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int BE_W      = 4;
  localparam int DATA_W    = 32;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Expand one enable bit per byte into a full byte mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int n = 0; n < BE_W; n++) begin
      mask[8*n +: 8] = {8{be[n]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// -----------------------------------------------------------------------------
// dmem_byte_array
// Little-endian byte storage of 2^ADDR_W bytes. One base address feeds four
// byte lanes (lane n touches addr+n); each lane has its own write enable.
// Reads are combinational; writes commit on the rising edge of clk.
// Storage is never cleared; its power-up contents are mem[i] = i mod 256.
//
// Ports:
//   clk    in  clock
//   addr   in  [ADDR_W-1:0] base byte address of the word access
//   we     in  [BE_W-1:0]   per-lane write enable
//   wdata  in  [DATA_W-1:0] write data, lane n = bits 8n+7:8n
//   rdata  out [DATA_W-1:0] read data, lane n = mem[addr+n]
// -----------------------------------------------------------------------------
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [7:0] mem_t [DEPTH];

  // Power-up image: every byte holds the low 8 bits of its own address.
  function automatic mem_t init_contents();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 8'(i);
    end
    return m;
  endfunction

  mem_t mem = init_contents();

  logic [ADDR_W-1:0] lane_addr [BE_W];

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      // Lane addresses wrap inside the array; the caller never enables a
      // lane whose true address lies outside it.
      assign lane_addr[gi]       = addr + ADDR_W'(gi);
      assign rdata[8*gi +: 8]    = mem[lane_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int n = 0; n < BE_W; n++) begin
      if (we[n]) begin
        mem[lane_addr[n]] <= wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core load/store port. Accepts one request at
// a time, waits LATENCY cycles, performs a byte-enabled read or write on the
// byte array, then holds the response until the core takes it.
//
// Build option: DMEM_MISALIGN_ERR_EN
//   defined   : req_addr[1:0] != 0 faults (rsp_err=1, no write, rdata 0)
//   undefined : req_addr[1:0] ignored, access goes to {addr[31:2],2'b00}
//
// Parameters:
//   ADDR_W   byte-address width of storage (2^ADDR_W bytes)
//   LATENCY  cycles from request acceptance to rsp_valid, 1..15
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request
//   req_we     in   1 = store, 0 = load
//   req_addr   in   [31:0] byte address
//   req_wdata  in   [31:0] store data, byte 0 = bits 7:0
//   req_be     in   [3:0]  byte enables, bit n selects byte addr+n
//   rsp_valid  out  response present
//   rsp_ready  in   core accepts response
//   rsp_rdata  out  [31:0] load data, 0 for stores and errors
//   rsp_err    out  request faulted
// -----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_W < 2 || ADDR_W > 31) begin : g_bad_addr_w
      $error("data_mem_responder: ADDR_W must be in 2..31");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  dmem_state_e          state_reg, state_next;
  logic [LAT_CNT_W-1:0] cnt_reg,   cnt_next;
  logic                 we_reg,    we_next;
  logic [31:0]          addr_reg,  addr_next;
  logic [DATA_W-1:0]    wdata_reg, wdata_next;
  logic [BE_W-1:0]      be_reg,    be_next;
  logic [DATA_W-1:0]    rdata_reg, rdata_next;
  logic                 err_reg,   err_next;

  // ---------------------------------------------------------------------------
  // Address checks on the captured request
  // ---------------------------------------------------------------------------
  logic [31:0]       eff_addr;
  logic              misalign;
  logic [BE_W-1:0]   lane_oor;
  logic              access_err;

`ifdef DMEM_MISALIGN_ERR_EN
  assign eff_addr = addr_reg;
  assign misalign = |addr_reg[1:0];
`else
  logic unused_addr_lsb;
  assign eff_addr        = {addr_reg[31:2], 2'b00};
  assign misalign        = 1'b0;
  assign unused_addr_lsb = ^addr_reg[1:0];
`endif

  // The range check looks at the address the core asked for (addr+n), not
  // the aligned one, so a word straddling the top of storage always faults.
  // A 33-bit sum keeps addresses near 2^32 from wrapping back into range.
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_range
      logic [32:0] lane_sum;
      assign lane_sum     = {1'b0, addr_reg} + 33'(gi);
      assign lane_oor[gi] = be_reg[gi] & (|lane_sum[32:ADDR_W]);
    end
  endgenerate

  assign access_err = misalign | (|lane_oor);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [BE_W-1:0]   mem_we;
  logic [DATA_W-1:0] mem_rdata;

  dmem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .addr  (eff_addr[ADDR_W-1:0]),
    .we    (mem_we),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM: next-state, capture and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    mem_we     = '0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_next    = req_we;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          be_next    = req_be;
          cnt_next   = LAT_CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (cnt_reg == '0) begin
          // Access edge: commit the store or sample the load, then respond.
          mem_we     = be_reg & {BE_W{we_reg & ~access_err}};
          rdata_next = (we_reg || access_err) ? '0 : (mem_rdata & be_to_mask(be_reg));
          err_next   = access_err;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset on the access edge abandons the store.
    if (rst) begin
      mem_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int NV     = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event expected event within bound", name);
  endtask

  // One complete transaction; lat = negedges after the accept edge until
  // rsp_valid is seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat, output bit ok);
    int guard;
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    ok    = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      timeout_fail("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat   = 0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      lat++;
      guard++;
    end
    if (!rsp_valid) begin
      timeout_fail("rsp_timeout");
      return;
    end
    rdata     = rsp_rdata;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rsp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    ok = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          ok;
    int          guard;

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h1312_1110, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h5, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h23AD_21EF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_03FE, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    vecs[4]  = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 32'hFFFE_FDFC, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h6, 32'h0002_0100, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0080, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0080, 32'h0,         4'hF, 32'h8382_8180, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         4'h8, 32'hFF00_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0400, 32'h0,         4'h1, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0,         1'b1};
`ifdef DMEM_MISALIGN_ERR_EN
    vecs[12] = '{1'b0, 32'h0000_0011, 32'h0,         4'hF, 32'h0,         1'b1};
`else
    vecs[12] = '{1'b0, 32'h0000_0011, 32'h0,         4'hF, 32'h1312_1110, 1'b0};
`endif
    vecs[13] = '{1'b1, 32'h0000_0050, 32'h0123_4567, 4'hF, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 32'h0000_0050, 32'h0,         4'hF, 32'h0123_4567, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_03FC, 32'hAABB_CCDD, 4'h8, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 32'hAAFE_FDFC, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
    rst = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, ok);
      if (ok) begin
        check($sformatf("row%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("row%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
        check($sformatf("row%0d_latency", i), lat, LAT);
      end
      $display("txn row%0d we=%0b addr=%h be=%h rdata=%h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].be, rd, er, lat);
    end

    // Response stall with a second request held pending
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wdata = '0;
    req_be    = 4'hF;
    check("stall_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h14;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      check("stall_wait_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) begin
      timeout_fail("stall_rsp_timeout");
      req_valid = 1'b0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_rsp_rdata", rsp_rdata, 32'h1312_1110);
        check("stall_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("stall_after_hs_req_ready", {31'd0, req_ready}, 32'd1);
      check("stall_after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("stall_second_accepted", {31'd0, req_ready}, 32'd0);
      guard = 0;
      while (!rsp_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!rsp_valid) begin
        timeout_fail("stall_second_rsp_timeout");
      end else begin
        check("stall_second_rdata", rsp_rdata, 32'h1716_1514);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
      end
      $display("txn stall second load addr=14 rdata=%h", rsp_rdata);
    end

    // Reset while waiting abandons the store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    check("rstwait_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstwait_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstwait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (LAT + 2) begin
      @(negedge clk);
      check("rstwait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, ok);
    if (ok) begin
      check("rstwait_load_rdata", rd, 32'h4342_4140);
      check("rstwait_load_err", {31'd0, er}, 32'd0);
    end
    $display("txn reset-abandoned store then load addr=40 rdata=%h err=%0b", rd, er);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
